// File: rtl/is_equal_cmp_if.sv
// is_equal_cmp_if: operand/result bundle for the lane-wise equality comparator.
//   master : drives VALID_IN, LANE_SEL, DATA_IN_1, DATA_IN_2; observes results
//   slave  : the comparator; drives EQUAL, ALL_EQUAL, ANY_EQUAL, VALID_OUT
interface is_equal_cmp_if #(
    parameter int WIDTH = 32
);
    logic             VALID_IN;
    logic [1:0]       LANE_SEL;
    logic [WIDTH-1:0] DATA_IN_1;
    logic [WIDTH-1:0] DATA_IN_2;
    logic [WIDTH-1:0] EQUAL;
    logic             ALL_EQUAL;
    logic             ANY_EQUAL;
    logic             VALID_OUT;

    modport master (
        output VALID_IN, LANE_SEL, DATA_IN_1, DATA_IN_2,
        input  EQUAL, ALL_EQUAL, ANY_EQUAL, VALID_OUT
    );

    modport slave (
        input  VALID_IN, LANE_SEL, DATA_IN_1, DATA_IN_2,
        output EQUAL, ALL_EQUAL, ANY_EQUAL, VALID_OUT
    );
endinterface

// File: rtl/is_equal_cmp.sv
// is_equal_cmp: registered lane-wise bitwise-equality comparator.
//   CLK  : rising-edge clock
//   RST  : asynchronous active-high reset
//   bus  : is_equal_cmp_if.slave
//          VALID_IN/LANE_SEL/DATA_IN_1/DATA_IN_2 in,
//          EQUAL (per-lane mask), ALL_EQUAL, ANY_EQUAL, VALID_OUT out.
// LANE_SEL: 00 = 8-bit lanes, 01 = 16-bit, 10 = 32-bit, 11 = one WIDTH-bit lane.
// One-cycle latency; results hold while VALID_IN is low.
// WIDTH must be a positive multiple of 32.

// Per 32-bit chunk: byte compares are the only real comparators; wider
// lane sizes AND-reduce them, so all modes share one set of XOR trees.
module is_equal_lane (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [1:0]  lane_sel,
    output logic [31:0] mask,
    output logic        chunk_eq
);
    logic [3:0] byte_eq;
    logic [1:0] half_eq;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            byte_eq[i] = (a[i*8 +: 8] == b[i*8 +: 8]);
        end
        for (int j = 0; j < 2; j++) begin
            half_eq[j] = &byte_eq[j*2 +: 2];
        end
        chunk_eq = &byte_eq;
    end

    always_comb begin
        mask = '0;
        case (lane_sel)
            2'b00: for (int i = 0; i < 4; i++) mask[i*8 +: 8]   = {8{byte_eq[i]}};
            2'b01: for (int j = 0; j < 2; j++) mask[j*16 +: 16] = {16{half_eq[j]}};
            // 32-bit mode; full-width mode is resolved across chunks in the top
            default: mask = {32{chunk_eq}};
        endcase
    end
endmodule

module is_equal_cmp #(
    parameter int WIDTH = 32
) (
    input  logic           CLK,
    input  logic           RST,
    is_equal_cmp_if.slave  bus
);
    localparam int VEC_W     = 32;
    localparam int NUM_LANES = WIDTH / VEC_W;
    localparam int STAGES    = 1;

    typedef struct packed {
        logic [WIDTH-1:0] eq;
        logic             all_eq;
        logic             any_eq;
    } resp_t;

    logic [NUM_LANES-1:0][VEC_W-1:0] lane_mask;
    logic [NUM_LANES-1:0]            chunk_eq;
    logic [WIDTH-1:0]                mask_d;
    logic [STAGES:0]                 vld_pipe;
    resp_t                           resp_q;

    genvar g;
    generate
        for (g = 0; g < NUM_LANES; g++) begin : g_lane
            is_equal_lane u_lane (
                .a        (bus.DATA_IN_1[g*VEC_W +: VEC_W]),
                .b        (bus.DATA_IN_2[g*VEC_W +: VEC_W]),
                .lane_sel (bus.LANE_SEL),
                .mask     (lane_mask[g]),
                .chunk_eq (chunk_eq[g])
            );
        end
    endgenerate

    assign mask_d      = (bus.LANE_SEL == 2'b11) ? {WIDTH{&chunk_eq}} : lane_mask;
    assign vld_pipe[0] = bus.VALID_IN;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            vld_pipe[STAGES:1] <= '0;
            resp_q             <= '0;
        end else begin
            vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
            if (bus.VALID_IN) begin
                // summary flags come from the same sample as the mask
                resp_q.eq     <= mask_d;
                resp_q.all_eq <= &mask_d;
                resp_q.any_eq <= |mask_d;
            end
        end
    end

    assign bus.EQUAL     = resp_q.eq;
    assign bus.ALL_EQUAL = resp_q.all_eq;
    assign bus.ANY_EQUAL = resp_q.any_eq;
    assign bus.VALID_OUT = vld_pipe[STAGES];
endmodule

// File: tb/tb_is_equal_cmp.sv
module tb_is_equal_cmp;
    localparam int WIDTH = 32;

    typedef struct {
        logic [WIDTH-1:0] eq;
        logic             all_eq;
        logic             any_eq;
        int               cyc;
    } exp_t;

    typedef struct {
        logic [1:0]       sel;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] eq;
        logic             all_eq;
        logic             any_eq;
    } vec_t;

    logic CLK;
    logic RST;
    is_equal_cmp_if #(.WIDTH(WIDTH)) bus ();

    is_equal_cmp #(.WIDTH(WIDTH)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Hand-computed vectors; issued back-to-back, one per cycle.
    vec_t vecs[11] = '{
        '{2'b10, 32'd100,        32'd4,          32'h00000000, 1'b0, 1'b0},
        '{2'b10, 32'd256,        32'd256,        32'hFFFFFFFF, 1'b1, 1'b1},
        '{2'b10, 32'd0,          32'd256,        32'h00000000, 1'b0, 1'b0},
        '{2'b00, 32'h11223344,   32'h11AA3344,   32'hFF00FFFF, 1'b0, 1'b1},
        '{2'b01, 32'h11223344,   32'h11AA3344,   32'h0000FFFF, 1'b0, 1'b1},
        '{2'b00, 32'h80000000,   32'h00000000,   32'h00FFFFFF, 1'b0, 1'b1},
        '{2'b01, 32'h00000001,   32'h00000000,   32'hFFFF0000, 1'b0, 1'b1},
        '{2'b11, 32'h80000000,   32'h00000000,   32'h00000000, 1'b0, 1'b0},
        '{2'b00, 32'h01010101,   32'h00000000,   32'h00000000, 1'b0, 1'b0},
        '{2'b10, 32'h00000000,   32'h00000000,   32'hFFFFFFFF, 1'b1, 1'b1},
        '{2'b11, 32'h00000000,   32'h00000000,   32'hFFFFFFFF, 1'b1, 1'b1}
    };

    task automatic issue(input vec_t v);
        exp_t e;
        @(negedge CLK);
        bus.VALID_IN  = 1'b1;
        bus.LANE_SEL  = v.sel;
        bus.DATA_IN_1 = v.a;
        bus.DATA_IN_2 = v.b;
        e.eq     = v.eq;
        e.all_eq = v.all_eq;
        e.any_eq = v.any_eq;
        e.cyc    = cyc + 1;
        exp_q.push_back(e);
    endtask

    task automatic idle(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        @(negedge CLK);
        bus.VALID_IN  = 1'b0;
        bus.LANE_SEL  = 2'b00;
        bus.DATA_IN_1 = a;
        bus.DATA_IN_2 = b;
    endtask

    // Monitor: pops an expectation whenever VALID_OUT is seen.
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            cyc++;
            #1;
            if (bus.VALID_OUT === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid_out", 64'(bus.VALID_OUT), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("latency_cycle", 64'(cyc), 64'(e.cyc));
                    chk("equal",         64'(bus.EQUAL), 64'(e.eq));
                    chk("all_equal",     64'(bus.ALL_EQUAL), 64'(e.all_eq));
                    chk("any_equal",     64'(bus.ANY_EQUAL), 64'(e.any_eq));
                end
            end
        end
    end

    initial begin
        RST           = 1'b1;
        bus.VALID_IN  = 1'b0;
        bus.LANE_SEL  = 2'b00;
        bus.DATA_IN_1 = '0;
        bus.DATA_IN_2 = '0;
        #12;
        chk("reset_equal",     64'(bus.EQUAL), 64'd0);
        chk("reset_all_equal", 64'(bus.ALL_EQUAL), 64'd0);
        chk("reset_any_equal", 64'(bus.ANY_EQUAL), 64'd0);
        chk("reset_valid_out", 64'(bus.VALID_OUT), 64'd0);
        @(negedge CLK);
        RST = 1'b0;

        foreach (vecs[i]) issue(vecs[i]);

        // Idle with operands that would compare unequal: results must hold.
        idle(32'h12345678, 32'h87654321);
        idle(32'hDEADBEEF, 32'h00000000);
        @(negedge CLK);
        chk("hold_valid_out", 64'(bus.VALID_OUT), 64'd0);
        chk("hold_equal",     64'(bus.EQUAL), 64'hFFFFFFFF);
        chk("hold_all_equal", 64'(bus.ALL_EQUAL), 64'd1);
        chk("hold_any_equal", 64'(bus.ANY_EQUAL), 64'd1);

        // Asynchronous reset between edges while a result is showing.
        issue('{2'b10, 32'hCAFEF00D, 32'hCAFEF00D, 32'hFFFFFFFF, 1'b1, 1'b1});
        @(posedge CLK);
        #3;
        chk("pre_rst_valid_out", 64'(bus.VALID_OUT), 64'd1);
        chk("pre_rst_equal",     64'(bus.EQUAL), 64'hFFFFFFFF);
        RST = 1'b1;
        #1;
        chk("async_rst_equal",     64'(bus.EQUAL), 64'd0);
        chk("async_rst_all_equal", 64'(bus.ALL_EQUAL), 64'd0);
        chk("async_rst_any_equal", 64'(bus.ANY_EQUAL), 64'd0);
        chk("async_rst_valid_out", 64'(bus.VALID_OUT), 64'd0);
        idle('0, '0);
        @(negedge CLK);
        RST = 1'b0;
        repeat (2) begin
            @(negedge CLK);
            chk("post_rst_valid_out", 64'(bus.VALID_OUT), 64'd0);
            chk("post_rst_equal",     64'(bus.EQUAL), 64'd0);
        end

        repeat (2) @(negedge CLK);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
